act_skew_feeder: RTL and testbench
==================================

# act_skew_feeder

Upstream feeder for the weight-stationary `pe_array_4x4`. It accepts one unskewed activation vector per beat (one element per array row) on a valid/ready stream. It applies the diagonal systolic skew, so row r is delayed r cycles relative to row 0, and drives the array's `act_in_flat` and `enable`. It also runs the zero-fill drain after the last vector and pulses `done` when the array has received every activation.

## Interface
- `DATA_WIDTH`, 8, activation element width; matches the PE array.
- `ROWS`, 4, number of array rows / vector elements.
- `LEN_WIDTH`, 16, width of the vector-count field.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  launch pulse; honoured only in IDLE.
- `vec_len`  in  LEN_WIDTH  number of vectors in the job; sampled on accepted `start`.
- `in_valid`  in  1  activation beat valid.
- `in_ready`  out  1  beat accept; combinational, high only in STREAM.
- `in_data`  in  DATA_WIDTH*ROWS  vector; element r at `[r*DATA_WIDTH +: DATA_WIDTH]`.
- `act_out_flat`  out  DATA_WIDTH*ROWS  skewed activations to `act_in_flat`; same packing.
- `array_enable`  out  1  drives PE array `enable`; registered.
- `busy`  out  1  high in STREAM and DRAIN.
- `done`  out  1  one-cycle completion pulse; registered.

## Operation
- FSM has three states: IDLE, STREAM and DRAIN.
- **IDLE:**
  - `start` with `vec_len` != 0 -> STREAM; `vec_len` is latched and the beat counter is cleared.
  - `start` with `vec_len` == 0 -> stay in IDLE and pulse `done` the next cycle.
- **STREAM:**
  - `in_ready`=1.
  - Every cycle, each row's delay line shifts.
  - The row inputs take `in_data` when `in_valid` is high; otherwise all-zero (bubble).
  - The beat counter increments per accepted beat only.
  - On acceptance of beat `vec_len` -> DRAIN; the drain counter is loaded with ROWS-1.
- **DRAIN:**
  - Lines keep shifting with zeros injected; lasts ROWS cycles.
  - Counter at 0 -> IDLE, with `done`=1 in the first IDLE cycle.
- `start` outside IDLE is ignored; latched `vec_len` is unaffected.
- `in_data` is ignored whenever `in_ready`=0.
- Row r delay line is r+1 registers deep, ROWS*(ROWS+1)/2 registers total. Data passes through untransformed: no arithmetic, no sign handling.
- `rst` at any time, including mid-STREAM or DRAIN:
  - next cycle, all delay registers and counters are 0 and the state is IDLE;
  - `done`, `busy`, `array_enable` and `act_out_flat` are 0;
  - no `done` is issued for the aborted job.

## Timing
- Reset values: `act_out_flat`=0, `array_enable`=0, `busy`=0, `done`=0, `in_ready`=0.
- A beat accepted at rising edge T appears on row r of `act_out_flat` after edge T+r+1. It is held one cycle so the array captures it at edge T+r+2.
- `array_enable` and `busy` rise after the edge that accepts `start` and fall after the final DRAIN edge.
- For back-to-back beats, `in_ready` falls in the cycle after the last acceptance, because the state is already DRAIN.
- Last beat accepted at edge T -> `done` high for exactly the cycle following edge T+ROWS+1. `act_out_flat` is all-zero in that cycle.
- Max job length is 2^LEN_WIDTH-1 vectors; the beat counter never wraps.
- A new `start` is accepted in the same cycle `done` is high.

## Configuration
- `ACT_SKEW_PERF_EN` defined:
  - adds output `bubble_cycles`, 32 bits, registered;
  - counts STREAM cycles with `in_valid`=0;
  - cleared on accepted `start` and on `rst`;
  - saturates at all-ones.
- `ACT_SKEW_PERF_EN` undefined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `act_skew_pkg` holds:
  - the FSM state encoding (IDLE/STREAM/DRAIN localparams);
  - the default `DATA_WIDTH`/`ROWS` constants shared with the PE array.
- Sub-module `act_skew_line`: a parameterised-depth, DATA_WIDTH-wide shift register with synchronous clear. It is instantiated once per row via generate, with depth r+1.
- The top holds the FSM, counters, handshake and the optional perf counter.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `start`=1 -> all outputs 0, `in_ready`=0, no transition out of IDLE.
- **Single vector:** `vec_len`=1, beat {r0..r3}={10,11,12,13} accepted at edge T:
  - `act_out_flat` row0=10 after T+1, row1=11 after T+2, row2=12 after T+3, row3=13 after T+4;
  - all other slots 0;
  - `done` after T+5.
- **Streaming:** `vec_len`=3, back-to-back beats of 1s, 2s and 3s -> diagonal pattern on `act_out_flat`, e.g. after T+3 rows = {3,2,1,0}; `in_ready` low after the third acceptance.
- **Bubbles:** `vec_len`=2 with `in_valid` low for 2 cycles between beats:
  - the zero gap appears, skewed, on every row;
  - `done` is delayed by 2 cycles;
  - with `ACT_SKEW_PERF_EN`, `bubble_cycles`=2.
- **Zero length / busy start:** `start` with `vec_len`=0 -> `done` next cycle, `busy` never high. A second `start` pulse during DRAIN is ignored.
- **Reset mid-DRAIN:** assert `rst` in the 2nd DRAIN cycle -> next cycle all outputs 0, and no `done` pulse within the following 10 cycles.

Source files
------------

// File: rtl/act_skew_pkg.sv
// Shared constants and FSM encoding for the activation skew feeder.
// Defaults match the pe_array_4x4 geometry.
package act_skew_pkg;

    localparam int unsigned ACT_DATA_WIDTH = 8;
    localparam int unsigned ACT_ROWS       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/act_skew_line.sv
// Fixed-depth shift register for one row of the diagonal skew.
// The line advances only when shift_en_i is set; rst clears every stage.
module act_skew_line
    import act_skew_pkg::*;
#(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = ACT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] line_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            line_q[0] <= din_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign dout_o = line_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Skews unskewed activation vectors onto the PE array rows and drains with zeros.
// Define ACT_SKEW_PERF_EN to add the bubble_cycles stall counter output.
module act_skew_feeder
    import act_skew_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int unsigned ROWS       = ACT_ROWS,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_WIDTH-1:0]       vec_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH*ROWS-1:0] in_data,
    output logic [DATA_WIDTH*ROWS-1:0] act_out_flat,
    output logic                       array_enable,
    output logic                       busy,
    output logic                       done
`ifdef ACT_SKEW_PERF_EN
    ,
    output logic [31:0]                bubble_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(ROWS + 1);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]     drain_q, drain_d;
    logic                 done_q, done_d;
    logic                 enable_q;
    logic                 accept;
    logic                 shift_en;

    assign in_ready     = (state_q == ST_STREAM);
    assign accept       = in_ready && in_valid;
    assign shift_en     = (state_q != ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign array_enable = enable_q;
    assign done         = done_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (vec_len != '0) begin
                        state_d = ST_STREAM;
                        len_d   = vec_len;
                        beat_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (in_valid) begin
                    beat_d = beat_q + 1'b1;
                    // len_q is never 0 here, so len_q-1 cannot underflow.
                    if (beat_q == len_q - 1'b1) begin
                        state_d = ST_DRAIN;
                        drain_d = CNT_W'(ROWS - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            beat_q   <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            enable_q <= (state_d != ST_IDLE);
        end
    end

    // Row r is r+1 stages deep, producing the diagonal wavefront.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_WIDTH-1:0] row_din;
        assign row_din = accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        act_skew_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_line (
            .clk        (clk),
            .rst        (rst),
            .shift_en_i (shift_en),
            .din_i      (row_din),
            .dout_o     (act_out_flat[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifdef ACT_SKEW_PERF_EN
    logic [31:0] bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            bubble_q <= '0;
        end else if (state_q == ST_STREAM && !in_valid && bubble_q != '1) begin
            bubble_q <= bubble_q + 1'b1;
        end
    end

    assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder: skew timing, drain, done, bubbles, resets.
module tb_act_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] vec_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] act_out_flat;
    logic        array_enable;
    logic        busy;
    logic        done;
`ifdef ACT_SKEW_PERF_EN
    logic [31:0] bubble_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    act_skew_feeder #(
        .DATA_WIDTH (8),
        .ROWS       (4),
        .LEN_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vec_len      (vec_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .act_out_flat (act_out_flat),
        .array_enable (array_enable),
        .busy         (busy),
        .done         (done)
`ifdef ACT_SKEW_PERF_EN
        ,
        .bubble_cycles(bubble_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; both driving and sampling happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int done_seen;

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        vec_len  = 16'd5;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held with start asserted
        repeat (3) tick();
        chk("rst_act",    act_out_flat, 32'h0);
        chk("rst_en",     array_enable, 1'b0);
        chk("rst_busy",   busy,         1'b0);
        chk("rst_done",   done,         1'b0);
        chk("rst_ready",  in_ready,     1'b0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);

        // Single vector {10,11,12,13}
        start   = 1'b1;
        vec_len = 16'd1;
        tick();
        start = 1'b0;
        chk("sv_busy",  busy,         1'b1);
        chk("sv_en",    array_enable, 1'b1);
        chk("sv_ready", in_ready,     1'b1);
        in_valid = 1'b1;
        in_data  = 32'h0D0C0B0A;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hFFFFFFFF;
        chk("sv_t1",       act_out_flat, 32'h0000000A);
        chk("sv_ready_lo", in_ready,     1'b0);
        tick();
        chk("sv_t2", act_out_flat, 32'h00000B00);
        tick();
        chk("sv_t3", act_out_flat, 32'h000C0000);
        tick();
        chk("sv_t4",      act_out_flat, 32'h0D000000);
        chk("sv_t4_en",   array_enable, 1'b1);
        chk("sv_t4_done", done,         1'b0);
        tick();
        chk("sv_done",      done,         1'b1);
        chk("sv_done_act",  act_out_flat, 32'h0);
        chk("sv_done_en",   array_enable, 1'b0);
        chk("sv_done_busy", busy,         1'b0);

        // New start in the done cycle: 3 back-to-back beats
        start   = 1'b1;
        vec_len = 16'd3;
        tick();
        start = 1'b0;
        chk("bb_done_lo", done,     1'b0);
        chk("bb_busy",    busy,     1'b1);
        chk("bb_ready",   in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h01010101;
        tick();
        in_data = 32'h02020202;
        chk("st_t1", act_out_flat, 32'h00000001);
        tick();
        in_data = 32'h03030303;
        chk("st_t2",       act_out_flat, 32'h00000102);
        chk("st_t2_ready", in_ready,     1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk("st_t3",       act_out_flat, 32'h00010203);
        chk("st_t3_ready", in_ready,     1'b0);
        tick();
        chk("st_t4", act_out_flat, 32'h01020300);
        tick();
        chk("st_t5", act_out_flat, 32'h02030000);
        tick();
        chk("st_t6",      act_out_flat, 32'h03000000);
        chk("st_t6_done", done,         1'b0);
        tick();
        chk("st_done",     done,         1'b1);
        chk("st_done_act", act_out_flat, 32'h0);
        tick();

        // Two beats separated by two bubble cycles
        start   = 1'b1;
        vec_len = 16'd2;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h04040404;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hAAAAAAAA;
        chk("bu_t1", act_out_flat, 32'h00000004);
        tick();
        chk("bu_t2", act_out_flat, 32'h00000400);
        tick();
        in_valid = 1'b1;
        in_data  = 32'h05050505;
        chk("bu_t3", act_out_flat, 32'h00040000);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk("bu_t4", act_out_flat, 32'h04000005);
        tick();
        chk("bu_t5", act_out_flat, 32'h00000500);
        tick();
        chk("bu_t6", act_out_flat, 32'h00050000);
        tick();
        chk("bu_t7",      act_out_flat, 32'h05000000);
        chk("bu_t7_done", done,         1'b0);
        tick();
        chk("bu_done",     done,         1'b1);
        chk("bu_done_act", act_out_flat, 32'h0);
`ifdef ACT_SKEW_PERF_EN
        chk("bu_perf", bubble_cycles, 32'd2);
`endif
        tick();

        // Zero-length job
        start   = 1'b1;
        vec_len = 16'd0;
        tick();
        start = 1'b0;
        chk("zl_done", done, 1'b1);
        chk("zl_busy", busy, 1'b0);
        tick();
        chk("zl_done_lo", done, 1'b0);
        chk("zl_busy2",   busy, 1'b0);

        // Start pulse during DRAIN is ignored
        start   = 1'b1;
        vec_len = 16'd1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h07070707;
        tick();
        in_valid = 1'b0;
        tick();
        start   = 1'b1;
        vec_len = 16'd9;
        tick();
        start = 1'b0;
        chk("ig_busy", busy, 1'b1);
        tick();
        chk("ig_t4", act_out_flat, 32'h07000000);
        tick();
        chk("ig_done", done, 1'b1);
        chk("ig_busy_lo", busy, 1'b0);
        tick();
        chk("ig_idle_busy",  busy,     1'b0);
        chk("ig_idle_ready", in_ready, 1'b0);

        // Reset in the second DRAIN cycle
        start   = 1'b1;
        vec_len = 16'd2;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h08080808;
        tick();
        in_data = 32'h09090909;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        chk("rd_pre", act_out_flat, 32'h00080900);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rd_act",   act_out_flat, 32'h0);
        chk("rd_busy",  busy,         1'b0);
        chk("rd_en",    array_enable, 1'b0);
        chk("rd_done",  done,         1'b0);
        chk("rd_ready", in_ready,     1'b0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("rd_no_done", done_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
